// File: rtl/stdp_weight_mem_ctrl_if.sv
// Bus between the STDP weight controller, the learning engine and the neuron core.
interface stdp_weight_mem_ctrl_if #(
   parameter int WEIGHT_SIZE = 16,
   parameter int ADDR_W      = 6
);
   logic                   req_valid;
   logic [ADDR_W-1:0]      req_addr;
   logic                   req_ready;
   logic                   stdp_start;
   logic [WEIGHT_SIZE-1:0] weight_before;
   logic                   stdp_done;
   logic [WEIGHT_SIZE-1:0] weight_after;
   logic [ADDR_W-1:0]      rd_addr;
   logic [WEIGHT_SIZE-1:0] rd_data;
   logic                   upd_done;
   logic                   upd_err;

   modport master (
      output req_valid, req_addr, stdp_done, weight_after, rd_addr,
      input  req_ready, stdp_start, weight_before, rd_data,
             upd_done, upd_err
   );

   modport slave (
      input  req_valid, req_addr, stdp_done, weight_after, rd_addr,
      output req_ready, stdp_start, weight_before, rd_data,
             upd_done, upd_err
   );
endinterface

// File: rtl/stdp_weight_mem_ctrl.sv
// Synaptic weight store with read-modify-write sequencing for STDP updates.
// Optional macro WEIGHT_CLAMP_EN clamps written weights to [W_MIN, W_MAX].
module stdp_weight_mem_ctrl #(
   parameter int                     WEIGHT_SIZE = 16,
   parameter int                     NUM_SYN     = 64,
   parameter int                     ADDR_W      = 6,
   parameter logic [WEIGHT_SIZE-1:0] INIT_WEIGHT = 16'h0800,
   parameter int                     TIMEOUT     = 15,
   parameter logic [WEIGHT_SIZE-1:0] W_MIN       = 16'h0010,
   parameter logic [WEIGHT_SIZE-1:0] W_MAX       = 16'hF000
) (
   input logic                  clk,
   input logic                  rst,
   stdp_weight_mem_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_ISSUE,
      S_WAIT,
      S_WRITE
   } state_t;

   state_t                 state;
   state_t                 state_n;
   logic [ADDR_W-1:0]      addr_q;
   logic [WEIGHT_SIZE-1:0] wb_q;
   logic [WEIGHT_SIZE-1:0] wa_q;
   logic [WEIGHT_SIZE-1:0] rd_q;
   logic [WEIGHT_SIZE-1:0] wr_val;
   logic [3:0]             cnt;
   logic [WEIGHT_SIZE-1:0] mem [NUM_SYN];

   logic ready;
   logic start;
   logic done;
   logic err;

   if (W_MIN > W_MAX) begin : g_bad_range
      $error("W_MIN must not exceed W_MAX");
   end

`ifdef WEIGHT_CLAMP_EN
   assign wr_val = (wa_q < W_MIN) ? W_MIN :
                   (wa_q > W_MAX) ? W_MAX : wa_q;
`else
   assign wr_val = wa_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      ready   = 1'b0;
      start   = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
      unique case (state)
         S_IDLE: begin
            ready = 1'b1;
            if (bus.req_valid) state_n = S_READ;
         end
         S_READ: state_n = S_ISSUE;
         S_ISSUE: begin
            start   = 1'b1;
            state_n = S_WAIT;
         end
         S_WAIT: begin
            // A late done on the last allowed cycle still wins
            if (bus.stdp_done) begin
               state_n = S_WRITE;
            end else if (cnt == 4'(TIMEOUT - 1)) begin
               err     = 1'b1;
               state_n = S_IDLE;
            end
         end
         S_WRITE: begin
            done    = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         wb_q   <= '0;
         wa_q   <= '0;
         cnt    <= '0;
      end else begin
         if (state == S_IDLE && bus.req_valid) addr_q <= bus.req_addr;
         if (state == S_READ) wb_q <= mem[addr_q];
         if (state == S_ISSUE) cnt <= '0;
         else if (state == S_WAIT) cnt <= cnt + 4'd1;
         if (state == S_WAIT && bus.stdp_done) wa_q <= bus.weight_after;
      end
   end

   // Read port samples before the write lands: collisions return the old weight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q <= '0;
         for (int i = 0; i < NUM_SYN; i++) mem[i] <= INIT_WEIGHT;
      end else begin
         rd_q <= mem[bus.rd_addr];
         if (state == S_WRITE) mem[addr_q] <= wr_val;
      end
   end

   assign bus.req_ready     = ready;
   assign bus.stdp_start    = start;
   assign bus.weight_before = wb_q;
   assign bus.rd_data       = rd_q;
   assign bus.upd_done      = done;
   assign bus.upd_err       = err;
endmodule

// File: tb/tb_stdp_weight_mem_ctrl.sv
// Directed self-checking bench for stdp_weight_mem_ctrl.
module tb_stdp_weight_mem_ctrl;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   stdp_weight_mem_ctrl_if bus ();

   stdp_weight_mem_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_upd(input logic [5:0] a, input logic [15:0] w);
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      tick();
      bus.req_valid = 1'b0;
      tick();
      tick();
      bus.stdp_done    = 1'b1;
      bus.weight_after = w;
      tick();
      bus.stdp_done = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      checks++;
      if (bus.weight_before !== 16'h0000) begin
         errors++;
         $display("FAIL rst_wb got %h want 0000", bus.weight_before);
      end
      checks++;
      if (bus.rd_data !== 16'h0000) begin
         errors++;
         $display("FAIL rst_rd got %h want 0000", bus.rd_data);
      end
      checks++;
      if ({bus.stdp_start, bus.upd_done, bus.upd_err} !== 3'b000) begin
         errors++;
         $display("FAIL rst_pulses got %b want 000",
                  {bus.stdp_start, bus.upd_done, bus.upd_err});
      end
      @(negedge clk);
      rst = 1'b0;
      tick();
      bus.req_valid = 1'b1;
      bus.req_addr  = 6'd5;
      tick();
      bus.req_valid = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_busy got %b want 0", bus.req_ready);
      end
      rst              = 1'b1;
      bus.stdp_done    = 1'b1;
      bus.weight_after = 16'h1234;
      tick();
      rst           = 1'b0;
      bus.stdp_done = 1'b0;
      tick();
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_ready got %b want 1", bus.req_ready);
      end
      checks++;
      if (bus.upd_done !== 1'b0) begin
         errors++;
         $display("FAIL rst_nodone got %b want 0", bus.upd_done);
      end
      bus.rd_addr = 6'd5;
      tick();
      checks++;
      if (bus.rd_data !== 16'h0800) begin
         errors++;
         $display("FAIL rst_mem5 got %h want 0800", bus.rd_data);
      end
   endtask

   task automatic test_update();
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL upd_c0_ready got %b want 1", bus.req_ready);
      end
      bus.req_valid = 1'b1;
      bus.req_addr  = 6'd3;
      tick();
      bus.req_valid = 1'b0;
      checks++;
      if ({bus.req_ready, bus.stdp_start} !== 2'b00) begin
         errors++;
         $display("FAIL upd_c1 got %b want 00",
                  {bus.req_ready, bus.stdp_start});
      end
      tick();
      checks++;
      if (bus.stdp_start !== 1'b1) begin
         errors++;
         $display("FAIL upd_c2_start got %b want 1", bus.stdp_start);
      end
      checks++;
      if (bus.weight_before !== 16'h0800) begin
         errors++;
         $display("FAIL upd_c2_wb got %h want 0800", bus.weight_before);
      end
      tick();
      checks++;
      if ({bus.stdp_start, bus.upd_done} !== 2'b00) begin
         errors++;
         $display("FAIL upd_c3 got %b want 00",
                  {bus.stdp_start, bus.upd_done});
      end
      bus.stdp_done    = 1'b1;
      bus.weight_after = 16'h0880;
      tick();
      bus.stdp_done = 1'b0;
      checks++;
      if (bus.upd_done !== 1'b1) begin
         errors++;
         $display("FAIL upd_c4_done got %b want 1", bus.upd_done);
      end
      tick();
      checks++;
      if ({bus.req_ready, bus.upd_done} !== 2'b10) begin
         errors++;
         $display("FAIL upd_c5 got %b want 10",
                  {bus.req_ready, bus.upd_done});
      end
      bus.rd_addr = 6'd3;
      tick();
      checks++;
      if (bus.rd_data !== 16'h0880) begin
         errors++;
         $display("FAIL upd_mem3 got %h want 0880", bus.rd_data);
      end
   endtask

   task automatic test_timeout();
      int at = -1;
      bit seen_done = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_addr  = 6'd7;
      tick();
      bus.req_valid = 1'b0;
      for (int n = 2; n <= 40; n++) begin
         tick();
         if (bus.upd_done === 1'b1) seen_done = 1'b1;
         if (bus.upd_err === 1'b1) begin
            at = n;
            break;
         end
      end
      checks++;
      if (at != 17) begin
         errors++;
         $display("FAIL to_cycle got %0d want 17", at);
      end
      checks++;
      if (seen_done !== 1'b0) begin
         errors++;
         $display("FAIL to_nodone got %b want 0", seen_done);
      end
      tick();
      checks++;
      if ({bus.upd_err, bus.req_ready} !== 2'b01) begin
         errors++;
         $display("FAIL to_after got %b want 01",
                  {bus.upd_err, bus.req_ready});
      end
      bus.rd_addr = 6'd7;
      tick();
      checks++;
      if (bus.rd_data !== 16'h0800) begin
         errors++;
         $display("FAIL to_mem7 got %h want 0800", bus.rd_data);
      end
   endtask

   task automatic test_back_to_back();
      int  xfers = 0;
      int  starts = 0;
      int  dones = 0;
      int  busy_ready = 0;
      logic prev_start = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_addr  = 6'd9;
      for (int k = 0; k <= 5; k++) begin
         if (bus.req_valid && bus.req_ready) xfers++;
         if (bus.stdp_start) starts++;
         if (bus.upd_done) dones++;
         if (k >= 1 && k <= 4 && bus.req_ready) busy_ready++;
         bus.stdp_done    = prev_start;
         bus.weight_after = 16'h0900;
         prev_start       = bus.stdp_start;
         if (k == 4) bus.req_valid = 1'b0;
         if (k < 5) tick();
      end
      bus.stdp_done = 1'b0;
      checks++;
      if (xfers != 1) begin
         errors++;
         $display("FAIL bp_xfers got %0d want 1", xfers);
      end
      checks++;
      if (starts != 1 || dones != 1) begin
         errors++;
         $display("FAIL bp_ops got start %0d done %0d want 1 1",
                  starts, dones);
      end
      checks++;
      if (busy_ready != 0) begin
         errors++;
         $display("FAIL bp_ready got %0d want 0", busy_ready);
      end
      bus.rd_addr = 6'd9;
      tick();
      checks++;
      if (bus.rd_data !== 16'h0900) begin
         errors++;
         $display("FAIL bp_mem9 got %h want 0900", bus.rd_data);
      end
   endtask

   task automatic test_collision();
      bus.req_valid = 1'b1;
      bus.req_addr  = 6'd3;
      tick();
      bus.req_valid = 1'b0;
      tick();
      bus.stdp_done    = 1'b1;
      bus.weight_after = 16'hFFFF;
      tick();
      checks++;
      if (bus.upd_done !== 1'b0) begin
         errors++;
         $display("FAIL col_early got %b want 0", bus.upd_done);
      end
      bus.weight_after = 16'h0A00;
      tick();
      bus.stdp_done = 1'b0;
      checks++;
      if (bus.upd_done !== 1'b1) begin
         errors++;
         $display("FAIL col_done got %b want 1", bus.upd_done);
      end
      bus.rd_addr = 6'd3;
      tick();
      checks++;
      if (bus.rd_data !== 16'h0880) begin
         errors++;
         $display("FAIL col_old got %h want 0880", bus.rd_data);
      end
      tick();
      checks++;
      if (bus.rd_data !== 16'h0A00) begin
         errors++;
         $display("FAIL col_new got %h want 0A00", bus.rd_data);
      end
   endtask

   task automatic test_clamp();
      logic [15:0] hi_exp;
      logic [15:0] lo_exp;
`ifdef WEIGHT_CLAMP_EN
      hi_exp = 16'hF000;
      lo_exp = 16'h0010;
`else
      hi_exp = 16'hFFFF;
      lo_exp = 16'h0001;
`endif
      do_upd(6'd12, 16'hFFFF);
      do_upd(6'd13, 16'h0001);
      do_upd(6'd14, 16'h4000);
      bus.rd_addr = 6'd12;
      tick();
      checks++;
      if (bus.rd_data !== hi_exp) begin
         errors++;
         $display("FAIL clamp_hi got %h want %h", bus.rd_data, hi_exp);
      end
      bus.rd_addr = 6'd13;
      tick();
      checks++;
      if (bus.rd_data !== lo_exp) begin
         errors++;
         $display("FAIL clamp_lo got %h want %h", bus.rd_data, lo_exp);
      end
      bus.rd_addr = 6'd14;
      tick();
      checks++;
      if (bus.rd_data !== 16'h4000) begin
         errors++;
         $display("FAIL clamp_mid got %h want 4000", bus.rd_data);
      end
      bus.rd_addr = 6'd0;
      tick();
      checks++;
      if (bus.rd_data !== 16'h0800) begin
         errors++;
         $display("FAIL untouched got %h want 0800", bus.rd_data);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst              = 1'b1;
      bus.req_valid    = 1'b0;
      bus.req_addr     = '0;
      bus.stdp_done    = 1'b0;
      bus.weight_after = '0;
      bus.rd_addr      = '0;
      #12;
      test_reset();
      test_update();
      test_timeout();
      test_back_to_back();
      test_collision();
      test_clamp();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
